// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
// Waits for the data-SRAM response on loads, then aligns and extends the load data.
// Ports:
//   clk, reset (async active-low)
//   es_to_ms_valid / es_ms_bus[73:0] / ms_allow_in      : execute handshake
//   ms_to_ws_valid / ms_ws_bus[69:0] / ws_allow_in      : write-back handshake
//   ms_fwd_bus[38:0]                                    : forwarding bus to decode
//   data_sram_data_ok / data_sram_rdata[31:0]           : load response
// Build option: define MS_RDATA_BUF_EN to add the DONE state and the
// rdata_buf holding register. Without it, the SRAM must hold its response.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_ms_bus,
    output logic        ms_allow_in,
    input  logic        ws_allow_in,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_ws_bus,
    output logic [38:0] ms_fwd_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);

`ifdef MS_RDATA_BUF_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ms_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } ms_state_t;
`endif

    ms_state_t   state;
    ms_state_t   state_nx;

    logic        ms_valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic [31:0] alu_result;

    logic        ms_ready_go;
    logic        accept;
    logic        ld_pending;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] final_result;

    assign accept = es_to_ms_valid && ms_allow_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allow_in) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= '0;
            gr_we        <= 1'b0;
            dest         <= '0;
            res_from_mem <= 1'b0;
            load_op      <= '0;
            alu_result   <= '0;
        end else if (accept) begin
            {pc, gr_we, dest, res_from_mem, load_op, alu_result} <= es_ms_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Whenever the stage turns over, the state follows the incoming
    // instruction (or goes IDLE on a bubble); otherwise only a buffered
    // response can move it.
    always_comb begin
        state_nx = state;
        if (ms_allow_in) begin
            state_nx = (es_to_ms_valid && es_ms_bus[35]) ? WAIT : IDLE;
        end
`ifdef MS_RDATA_BUF_EN
        else if (state == WAIT && data_sram_data_ok) begin
            state_nx = DONE;
        end
`endif
    end

`ifdef MS_RDATA_BUF_EN
    logic [31:0] rdata_buf;

    // Stalled at write-back: keep the one-cycle response for later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_buf <= '0;
        end else if (state == WAIT && data_sram_data_ok && !ms_allow_in) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign ld_data = (state == DONE) ? rdata_buf : data_sram_rdata;
`else
    assign ld_data = data_sram_rdata;
`endif

    always_comb begin
        ms_ready_go = 1'b1;
        if (res_from_mem) begin
            ms_ready_go = (state == WAIT) && data_sram_data_ok;
`ifdef MS_RDATA_BUF_EN
            if (state == DONE) begin
                ms_ready_go = 1'b1;
            end
`endif
        end
    end

    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_comb begin
        ld_byte = ld_data[7:0];
        unique case (alu_result[1:0])
            2'd0: ld_byte = ld_data[7:0];
            2'd1: ld_byte = ld_data[15:8];
            2'd2: ld_byte = ld_data[23:16];
            2'd3: ld_byte = ld_data[31:24];
        endcase
    end

    assign ld_half = alu_result[1] ? ld_data[31:16] : ld_data[15:0];

    always_comb begin
        case (load_op)
            3'd1:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_ext = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_ext = {24'd0, ld_byte};
            3'd4:    ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_data;
        endcase
    end

    assign final_result = res_from_mem ? ld_ext : alu_result;

    assign ld_pending = ms_valid && res_from_mem && (state == WAIT)
                        && !data_sram_data_ok;

    assign ms_ws_bus  = ms_valid ? {pc, gr_we, dest, final_result} : '0;
    assign ms_fwd_bus = ms_valid ? {ld_pending, gr_we, dest, final_result} : '0;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Slot-level reference model plus table vectors and directed sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        es_to_ms_valid = 1'b0;
    logic [73:0] es_ms_bus = '0;
    logic        ms_allow_in;
    logic        ws_allow_in = 1'b0;
    logic        ms_to_ws_valid;
    logic [69:0] ms_ws_bus;
    logic [38:0] ms_fwd_bus;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_ms_bus         (es_ms_bus),
        .ms_allow_in       (ms_allow_in),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_ws_bus         (ms_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [73:0] act,
                       input logic [73:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: one instruction slot, plus a captured response.
    bit          m_valid, m_we, m_load, m_got;
    logic [31:0] m_pc, m_alu, m_buf;
    logic [4:0]  m_dest;
    logic [2:0]  m_op;

    logic        e_allow, e_tows, e_ready, e_pend;
    logic [31:0] e_res;
    logic [69:0] e_ws;
    logic [38:0] e_fwd;

    function automatic logic [31:0] ext(input logic [2:0] op,
                                        input logic [1:0] a,
                                        input logic [31:0] d);
        int unsigned b, h;
        b = (d >> (a * 8)) & 32'hff;
        h = (d >> (a[1] * 16)) & 32'hffff;
        case (op)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return (h >= 32768) ? h - 65536 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [73:0] mk_bus(input logic [31:0] pc,
                                           input logic we,
                                           input logic [4:0] dest,
                                           input logic ld,
                                           input logic [2:0] op,
                                           input logic [31:0] alu);
        return {pc, we, dest, ld, op, alu};
    endfunction

    task automatic model_eval();
        logic [31:0] d;
        e_ready = !m_load || m_got || data_sram_data_ok;
        d       = m_got ? m_buf : data_sram_rdata;
        e_res   = m_load ? ext(m_op, m_alu[1:0], d) : m_alu;
        e_allow = !m_valid || (e_ready && ws_allow_in);
        e_tows  = m_valid && e_ready;
        e_pend  = m_valid && m_load && !m_got && !data_sram_data_ok;
        e_ws    = m_valid ? {m_pc, m_we, m_dest, e_res} : '0;
        e_fwd   = m_valid ? {e_pend, m_we, m_dest, e_res} : '0;
    endtask

    task automatic model_update();
        if (!reset) begin
            m_valid = 0;
            m_got   = 0;
        end else begin
            model_eval();
            if (e_allow) begin
                m_valid = es_to_ms_valid;
                m_got   = 0;
                if (es_to_ms_valid) begin
                    {m_pc, m_we, m_dest, m_load, m_op, m_alu} = es_ms_bus;
                end
            end
`ifdef MS_RDATA_BUF_EN
            else if (m_valid && m_load && !m_got && data_sram_data_ok
                     && !ws_allow_in) begin
                m_got = 1;
                m_buf = data_sram_rdata;
            end
`endif
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("allow_in", ms_allow_in, e_allow);
        chk("to_ws_valid", ms_to_ws_valid, e_tows);
        chk("ws_bus", ms_ws_bus, e_ws);
        chk("fwd_bus", ms_fwd_bus, e_fwd);
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [73:0] bus,
                         input logic ws, input logic dok,
                         input logic [31:0] rd);
        es_to_ms_valid    = v;
        es_ms_bus         = bus;
        ws_allow_in       = ws;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vec[10];

    initial begin
        logic        hold_ok;
        logic [31:0] hold_rd;

        vec[0] = '{3'd1, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
        vec[1] = '{3'd4, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF};
        vec[2] = '{3'd0, 2'd0, 32'h1234_5678, 32'h1234_5678};
        vec[3] = '{3'd2, 2'd0, 32'h0000_8001, 32'hFFFF_8001};
        vec[4] = '{3'd3, 2'd1, 32'h0000_F100, 32'h0000_00F1};
        vec[5] = '{3'd1, 2'd0, 32'hFFFF_FF7F, 32'h0000_007F};
        vec[6] = '{3'd6, 2'd1, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vec[7] = '{3'd2, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF};
        vec[8] = '{3'd4, 2'd0, 32'h0000_FFFF, 32'h0000_FFFF};
        vec[9] = '{3'd3, 2'd2, 32'h0080_0000, 32'h0000_0080};

        m_valid = 0;
        m_got   = 0;

        // Reset state
        settle();
        chk("rst_allow_in", ms_allow_in, 1'b1);
        chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
        chk("rst_fwd_bus", ms_fwd_bus, 39'd0);
        chk("rst_ws_bus", ms_ws_bus, 70'd0);
        tick();
        tick();
        reset = 1'b1;

        // Non-load, one-cycle latency
        drive(1, mk_bus(32'h1c00_0000, 1, 5'd5, 0, 3'd0, 32'h1234), 1, 0, 0);
        settle();
        tick();
        drive(0, '0, 1, 0, 0);
        settle();
        chk("alu_ws_bus", ms_ws_bus, {32'h1c00_0000, 1'b1, 5'd5, 32'h1234});
        chk("alu_to_ws_valid", ms_to_ws_valid, 1'b1);
        tick();

        // ld.b, two waiting cycles
        drive(1, mk_bus(32'h1c00_0010, 1, 5'd7, 1, 3'd1, 32'h2003), 1, 0, 0);
        settle();
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 1, 0, 32'h5555_5555);
            settle();
            chk("ldb_pending", ms_fwd_bus[38], 1'b1);
            chk("ldb_wait_valid", ms_to_ws_valid, 1'b0);
            tick();
        end
        drive(0, '0, 1, 1, 32'h80FF_0000);
        settle();
        chk("ldb_result", ms_ws_bus[31:0], 32'hFFFF_FF80);
        chk("ldb_fwd_result", ms_fwd_bus[31:0], 32'hFFFF_FF80);
        chk("ldb_pending_clr", ms_fwd_bus[38], 1'b0);
        chk("ldb_to_ws_valid", ms_to_ws_valid, 1'b1);
        tick();

        // Response while write-back is stalled
        drive(1, mk_bus(32'h1c00_0020, 1, 5'd9, 1, 3'd0, 32'h3000), 1, 0, 0);
        settle();
        tick();
        drive(0, '0, 0, 1, 32'hCAFE_F00D);
        settle();
        chk("stall_result", ms_ws_bus[31:0], 32'hCAFE_F00D);
        tick();
`ifdef MS_RDATA_BUF_EN
        hold_ok = 1'b0;
        hold_rd = 32'h0;
`else
        hold_ok = 1'b1;
        hold_rd = 32'hCAFE_F00D;
`endif
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 0, hold_ok, hold_rd);
            settle();
            chk("stall_hold_result", ms_ws_bus[31:0], 32'hCAFE_F00D);
            chk("stall_hold_valid", ms_to_ws_valid, 1'b1);
            chk("stall_hold_pending", ms_fwd_bus[38], 1'b0);
            chk("stall_hold_allow", ms_allow_in, 1'b0);
            tick();
        end
        drive(0, '0, 1, hold_ok, hold_rd);
        settle();
        chk("stall_release_result", ms_ws_bus[31:0], 32'hCAFE_F00D);
        chk("stall_release_allow", ms_allow_in, 1'b1);
        tick();
        drive(0, '0, 1, 1, 32'h1111_1111);
        settle();
        chk("stray_ok_valid", ms_to_ws_valid, 1'b0);
        tick();

        // Reset asserted while a load waits, stray response afterwards
        drive(1, mk_bus(32'h1c00_0030, 1, 5'd3, 1, 3'd0, 32'h4000), 1, 0, 0);
        settle();
        tick();
        drive(0, '0, 1, 0, 0);
        settle();
        chk("rstw_pending", ms_fwd_bus[38], 1'b1);
        reset   = 1'b0;
        m_valid = 0;
        m_got   = 0;
        #1;
        chk("rstw_async_valid", ms_to_ws_valid, 1'b0);
        chk("rstw_async_fwd", ms_fwd_bus, 39'd0);
        tick();
        reset = 1'b1;
        drive(0, '0, 1, 1, 32'hDEAD_BEEF);
        settle();
        chk("rstw_stray_valid", ms_to_ws_valid, 1'b0);
        chk("rstw_stray_fwd", ms_fwd_bus, 39'd0);
        chk("rstw_stray_ws", ms_ws_bus, 70'd0);
        chk("rstw_allow", ms_allow_in, 1'b1);
        tick();
        drive(0, '0, 1, 0, 0);
        settle();
        tick();

        // Table: back-to-back loads, response in the following cycle
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                drive(1, mk_bus(32'h1c00_0100 + i * 4, 1, 5'(i + 1), 1,
                                vec[i].op, {30'h400, vec[i].addr}),
                      1, i > 0, (i > 0) ? vec[i - 1].rdata : 32'h0);
            end else begin
                drive(0, '0, 1, 1, vec[9].rdata);
            end
            settle();
            chk("b2b_allow_in", ms_allow_in, 1'b1);
            if (i > 0) begin
                chk("b2b_result", ms_ws_bus[31:0], vec[i - 1].exp);
                chk("b2b_to_ws_valid", ms_to_ws_valid, 1'b1);
            end
            tick();
        end
        drive(0, '0, 1, 0, 0);
        settle();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0,
                  mk_bus($urandom, 1'($urandom), 5'($urandom),
                         1'($urandom), 3'($urandom), $urandom),
                  ($urandom % 4) != 0, ($urandom % 3) == 0, $urandom);
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
